// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: triggers on a positive zero crossing (or timeout), captures
// one frame into the RAM half the display is not reading, then flips read_index
// during display idle time so the new frame appears without tearing.
module wave_capture_ctrl #(
  parameter int unsigned SAMPLES = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        play,
  input  logic        wave_display_idle,
  output logic [8:0]  write_address,
  output logic [7:0]  write_sample,
  output logic        write_enable,
  output logic        read_index,
  output logic        frame_swap
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]    LAST_COUNT = 8'(SAMPLES - 1);
  localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_count;
  logic [7:0]    w_count;
  logic [TW-1:0] r_tcount;
  logic [TW-1:0] w_tcount;
  logic [15:0]   r_prev_sample;
  logic          r_read_index;
  logic          w_read_index;
  logic          r_write_enable;
  logic          w_write_enable;
  logic [8:0]    r_write_address;
  logic [8:0]    w_write_address;
  logic [7:0]    r_write_sample;
  logic [7:0]    w_write_sample;
  logic          r_frame_swap;
  logic          w_frame_swap;

  logic          w_crossing;
  logic          w_trigger;
  logic [7:0]    w_offset_sample;

  // Previous sample negative and current sample non-negative (sign-bit crossing).
  assign w_crossing      = ($signed(r_prev_sample) < 16'sd0) && ($signed(new_sample_in) >= 16'sd0);
  assign w_trigger       = play && (w_crossing || (r_tcount == LAST_TICK));
  assign w_offset_sample = {~new_sample_in[15], new_sample_in[14:8]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ARMED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ARMED: begin
        if (new_sample_ready && w_trigger) begin
          w_next_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready && (r_count == LAST_COUNT)) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wave_display_idle) begin
          w_next_state = S_ARMED;
        end
      end
      default: w_next_state = S_ARMED;
    endcase
  end

  // Output/datapath next values; address and data hold when no write is issued
  always_comb begin
    w_write_enable  = 1'b0;
    w_write_address = r_write_address;
    w_write_sample  = r_write_sample;
    w_count         = r_count;
    w_tcount        = r_tcount;
    w_read_index    = r_read_index;
    w_frame_swap    = 1'b0;
    case (r_state)
      S_ARMED: begin
        if (new_sample_ready) begin
          if (w_trigger) begin
            w_write_enable  = 1'b1;
            w_write_address = {~r_read_index, 8'd0};
            w_write_sample  = w_offset_sample;
            w_count         = 8'd1;
            w_tcount        = '0;
          end else if (r_tcount != LAST_TICK) begin
            w_tcount = r_tcount + TW'(1);
          end
        end
      end
      S_ACTIVE: begin
        w_tcount = '0;
        if (new_sample_ready) begin
          w_write_enable  = 1'b1;
          w_write_address = {~r_read_index, r_count};
          w_write_sample  = w_offset_sample;
          w_count         = (r_count == LAST_COUNT) ? 8'd0 : r_count + 8'd1;
        end
      end
      S_WAIT: begin
        w_tcount = '0;
        if (wave_display_idle) begin
          w_read_index = ~r_read_index;
          w_frame_swap = 1'b1;
        end
      end
      default: begin
        w_count  = 8'd0;
        w_tcount = '0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= 8'd0;
      r_tcount        <= '0;
      r_prev_sample   <= 16'd0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= 9'd0;
      r_write_sample  <= 8'd0;
      r_frame_swap    <= 1'b0;
    end else begin
      r_count         <= w_count;
      r_tcount        <= w_tcount;
      r_read_index    <= w_read_index;
      r_write_enable  <= w_write_enable;
      r_write_address <= w_write_address;
      r_write_sample  <= w_write_sample;
      r_frame_swap    <= w_frame_swap;
      if (new_sample_ready) begin
        r_prev_sample <= new_sample_in;
      end
    end
  end

  assign write_address = r_write_address;
  assign write_sample  = r_write_sample;
  assign write_enable  = r_write_enable;
  assign read_index    = r_read_index;
  assign frame_swap    = r_frame_swap;

endmodule
